stream_mux: RTL and testbench

Parametrised N-input, WIDTH-bit valid/ready stream multiplexer with a registered output stage. It is the next generation of the datapath 2:1 select. It adds channel count, selectable arbitration mode (external select or round-robin), backpressure and one cycle of latency. It sits between multiple producers (e.g. writeback sources, memory request ports) and a single consumer in the RISC-V core.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/stream_mux_rr_arbiter.sv | 49 ++++
 rtl/stream_mux.sv | 80 ++++++++
 tb/tb_stream_mux.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// ============================================================================
// stream_mux_pkg : arbitration mode encodings for stream_mux
// Revision 1.0
// ============================================================================
`default_nettype none

package stream_mux_pkg;

  localparam int SEL_EXT = 0;
  localparam int SEL_RR  = 1;

endpackage : stream_mux_pkg

`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin arbiter, search starts one past the last winner
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [CH_W-1:0] r_last;
  logic            w_found;
  int              w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = (int'(r_last) + k) % NUM_CH;
      if (!w_found && req[w_idx]) begin
        w_found        = 1'b1;
        gnt[w_idx]     = 1'b1;
        gnt_idx        = CH_W'(w_idx);
      end
    end
  end

  // Reset to the top index so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= CH_W'(NUM_CH - 1);
    end else if (advance && w_found) begin
      r_last <= gnt_idx;
    end
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/stream_mux.sv
// ============================================================================
// stream_mux : N-input valid/ready stream multiplexer with registered output
// Revision 1.0
// ============================================================================
`default_nettype none

module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_CH   = 4,
  parameter int SEL_MODE = SEL_EXT,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] in_valid,
  output logic [NUM_CH-1:0] in_ready,
  input  logic [WIDTH-1:0]  in_data [NUM_CH],
  input  logic [CH_W-1:0]   sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch
);

  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_grant_idx;
  logic              w_free;
  logic              w_load;

  assign w_free = !out_valid || out_ready;
  assign w_load = w_free && (|w_grant);

  if (SEL_MODE == SEL_RR) begin : g_rr
    rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
    ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (in_valid),
      .advance (w_free),
      .gnt     (w_grant),
      .gnt_idx (w_grant_idx)
    );
  end else begin : g_ext
    // Compare against every index so an out-of-range sel matches nothing.
    always_comb begin
      w_grant     = '0;
      w_grant_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == CH_W'(i)) begin
          w_grant[i]  = in_valid[i];
          w_grant_idx = CH_W'(i);
        end
      end
    end
  end

  // Gated by rst_n so nothing is accepted while reset is held.
  assign in_ready = (rst_n && w_free) ? w_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (w_load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[w_grant_idx];
      out_ch    <= w_grant_idx;
    end else if (w_free) begin
      out_valid <= 1'b0;
    end
  end

endmodule : stream_mux

`default_nettype wire

// File: tb/tb_stream_mux.sv
// ============================================================================
// tb_stream_mux : directed checks of select, round-robin and 3-channel builds
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // External-select, 4 channels
  logic [3:0]  s_valid, s_ready;
  logic [31:0] s_data [4];
  logic [1:0]  s_sel, s_out_ch;
  logic        s_out_valid, s_out_ready;
  logic [31:0] s_out_data;

  // Round-robin, 4 channels
  logic [3:0]  r_valid, r_ready;
  logic [31:0] r_data [4];
  logic [1:0]  r_sel, r_out_ch;
  logic        r_out_valid, r_out_ready;
  logic [31:0] r_out_data;

  // External-select, 3 channels
  logic [2:0]  t_valid, t_ready;
  logic [31:0] t_data [3];
  logic [1:0]  t_sel, t_out_ch;
  logic        t_out_valid, t_out_ready;
  logic [31:0] t_out_data;

  stream_mux #(.WIDTH(32), .NUM_CH(4), .SEL_MODE(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
    .in_data(s_data), .sel(s_sel), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_ch(s_out_ch));

  stream_mux #(.WIDTH(32), .NUM_CH(4), .SEL_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(r_valid), .in_ready(r_ready),
    .in_data(r_data), .sel(r_sel), .out_valid(r_out_valid),
    .out_ready(r_out_ready), .out_data(r_out_data), .out_ch(r_out_ch));

  stream_mux #(.WIDTH(32), .NUM_CH(3), .SEL_MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_valid), .in_ready(t_ready),
    .in_data(t_data), .sel(t_sel), .out_valid(t_out_valid),
    .out_ready(t_out_ready), .out_data(t_out_data), .out_ch(t_out_ch));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] rr_exp [5];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held with every input valid
    rst_n = 1'b0;
    s_valid = 4'hF; r_valid = 4'hF; t_valid = 3'h7;
    s_sel = 2'd0; r_sel = 2'd0; t_sel = 2'd0;
    s_out_ready = 1'b1; r_out_ready = 1'b1; t_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data[i] = 32'h1000 + i;
      r_data[i] = 32'hA0 + i;
    end
    for (int i = 0; i < 3; i++) t_data[i] = 32'h300 + i;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, s_out_valid}, 32'd0);
    chk("rst_out_data", s_out_data, 32'd0);
    chk("rst_out_ch", {30'd0, s_out_ch}, 32'd0);
    chk("rst_in_ready", {28'd0, s_ready}, 32'd0);
    chk("rst_rr_in_ready", {28'd0, r_ready}, 32'd0);
    s_valid = 4'h0; r_valid = 4'h0; t_valid = 3'h0;
    rst_n = 1'b1;
    @(negedge clk);

    // Select mode: sel=2 with all channels valid
    s_sel = 2'd2; s_data[2] = 32'hDEADBEEF; s_valid = 4'hF;
    #1 chk("sel_in_ready", {28'd0, s_ready}, 32'h4);
    @(negedge clk);
    chk("sel_out_valid", {31'd0, s_out_valid}, 32'd1);
    chk("sel_out_data", s_out_data, 32'hDEADBEEF);
    chk("sel_out_ch", {30'd0, s_out_ch}, 32'd2);

    // Backpressure: hold beat three cycles, ch1 waiting
    s_out_ready = 1'b0; s_sel = 2'd1; s_valid = 4'h2; s_data[1] = 32'h11111111;
    for (int c = 0; c < 3; c++) begin
      #1 chk("hold_in_ready", {28'd0, s_ready}, 32'd0);
      @(negedge clk);
      chk("hold_out_valid", {31'd0, s_out_valid}, 32'd1);
      chk("hold_out_data", s_out_data, 32'hDEADBEEF);
      chk("hold_out_ch", {30'd0, s_out_ch}, 32'd2);
    end
    s_out_ready = 1'b1;
    #1 chk("drain_load_in_ready", {28'd0, s_ready}, 32'h2);
    @(negedge clk);
    chk("no_bubble_valid", {31'd0, s_out_valid}, 32'd1);
    chk("no_bubble_data", s_out_data, 32'h11111111);
    chk("no_bubble_ch", {30'd0, s_out_ch}, 32'd1);
    s_valid = 4'h0;
    @(negedge clk);
    chk("drain_valid", {31'd0, s_out_valid}, 32'd0);
    chk("drain_data_hold", s_out_data, 32'h11111111);
    chk("drain_ch_hold", {30'd0, s_out_ch}, 32'd1);

    // Round-robin, all channels valid
    r_valid = 4'hF;
    #1 chk("rr_first_ready", {28'd0, r_ready}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_out_valid", {31'd0, r_out_valid}, 32'd1);
      chk("rr_out_ch", {30'd0, r_out_ch}, {30'd0, rr_exp[k]});
      chk("rr_out_data", r_out_data, 32'hA0 + {30'd0, rr_exp[k]});
    end

    // Round-robin skip: only ch1 and ch3
    r_valid = 4'hA;
    #1 chk("rr_skip_ready", {28'd0, r_ready}, 32'h2);
    @(negedge clk); chk("rr_skip_a", {30'd0, r_out_ch}, 32'd1);
    @(negedge clk); chk("rr_skip_b", {30'd0, r_out_ch}, 32'd3);
    @(negedge clk); chk("rr_skip_c", {30'd0, r_out_ch}, 32'd1);
    r_valid = 4'h2;
    @(negedge clk);
    chk("rr_only1_a", {30'd0, r_out_ch}, 32'd1);
    chk("rr_only1_valid", {31'd0, r_out_valid}, 32'd1);
    @(negedge clk); chk("rr_only1_b", {30'd0, r_out_ch}, 32'd1);
    r_valid = 4'h0;

    // NUM_CH=3 with out-of-range sel
    t_sel = 2'd3; t_valid = 3'h7;
    #1 chk("sel3_in_ready", {29'd0, t_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("sel3_out_valid", {31'd0, t_out_valid}, 32'd0);
    t_sel = 2'd2;
    @(negedge clk);
    chk("sel3_ch2_valid", {31'd0, t_out_valid}, 32'd1);
    chk("sel3_ch2_data", t_out_data, 32'h302);
    t_valid = 3'h0;

    // Async reset drops a held beat
    s_sel = 2'd0; s_data[0] = 32'h55; s_valid = 4'h1; s_out_ready = 1'b0;
    @(negedge clk);
    s_valid = 4'h0;
    chk("pre_rst_valid", {31'd0, s_out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, s_out_valid}, 32'd0);
    chk("async_rst_data", s_out_data, 32'd0);
    s_valid = 4'h1;
    #0.5 chk("async_rst_ready", {28'd0, s_ready}, 32'd0);
    s_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("beat_lost", {31'd0, s_out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stream_mux

`default_nettype wire
